// File: rtl/spi_sram_burst_slave_pkg.sv
// Shared constants, state encoding and sizing helper for the SPI-to-SRAM burst slave.
package spi_sram_pkg;

  localparam int CMD_W      = 8;
  localparam int WORD_CNT_W = 16;

  localparam logic [CMD_W-1:0] CMD_WRITE = 8'h02;
  localparam logic [CMD_W-1:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WDATA  = 3'd3,
    ST_RDATA  = 3'd4,
    ST_IGNORE = 3'd5
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/spi_sram_burst_slave_if.sv
// SPI pin bundle between an external master and the SRAM burst slave.
interface spi_sram_burst_slave_if;
  import spi_sram_pkg::*;

  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic                  busy;
  logic                  frame_err;
  logic [WORD_CNT_W-1:0] word_cnt;

  modport slave (
    input  cs_n, mosi,
    output miso, miso_oe, busy, frame_err, word_cnt
  );

  modport master (
    output cs_n, mosi,
    input  miso, miso_oe, busy, frame_err, word_cnt
  );

endinterface

// File: rtl/spi_sram_burst_slave_sram_array.sv
// Word-wide memory: one write port clocked on falling SCK, one combinational read port.
module sram_array
  import spi_sram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(negedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spi_sram_burst_slave.sv
// SPI slave decoding command/address then bursting LSB-first words to or from the SRAM,
// auto-incrementing and wrapping the address at DEPTH.
module spi_sram_burst_slave
  import spi_sram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic                   SCK,
  input  logic                   rst,
  spi_sram_burst_slave_if.slave  bus
);

  localparam int MAX_W = (DATA_W > ADDR_W) ? ((DATA_W > CMD_W) ? DATA_W : CMD_W)
                                           : ((ADDR_W > CMD_W) ? ADDR_W : CMD_W);
  localparam int BCW   = clog2(MAX_W);

  localparam logic [BCW-1:0] CMD_LAST  = BCW'(CMD_W - 1);
  localparam logic [BCW-1:0] ADDR_LAST = BCW'(ADDR_W - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);

  state_e                state_q;
  logic [BCW-1:0]        bit_cnt_q;
  logic [CMD_W-1:0]      cmd_q;
  logic [ADDR_W-1:0]     addr_sh_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     rx_q;
  logic [DATA_W-1:0]     tx_q;
  logic                  is_read_q;
  logic                  miso_q;
  logic                  miso_oe_q;
  logic                  busy_q;
  logic                  frame_err_q;
  logic [WORD_CNT_W-1:0] word_cnt_q;

  logic [CMD_W-1:0]      cmd_d;
  logic [ADDR_W-1:0]     addr_sh_d;
  logic [ADDR_W-1:0]     addr_base_d;
  logic [ADDR_W-1:0]     addr_inc_d;
  logic [DATA_W-1:0]     rx_d;
  logic [WORD_CNT_W-1:0] word_cnt_d;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic                  mem_we;

  // Shift-in values, wrapped addresses and memory controls for the coming edge.
  always_comb begin
    cmd_d       = {bus.mosi, cmd_q[CMD_W-1:1]};
    addr_sh_d   = {bus.mosi, addr_sh_q[ADDR_W-1:1]};
    rx_d        = {bus.mosi, rx_q[DATA_W-1:1]};
    addr_base_d = ADDR_W'(32'(addr_sh_d) % 32'(DEPTH));
    addr_inc_d  = (32'(addr_q) == 32'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
    word_cnt_d  = (word_cnt_q == 16'hFFFF) ? word_cnt_q : word_cnt_q + 16'd1;
    // The address phase reads the start word; the data phase prefetches the next one.
    rd_addr     = (state_q == ST_ADDR) ? addr_base_d : addr_inc_d;
    mem_we      = !rst && !bus.cs_n && (state_q == ST_WDATA) && (bit_cnt_q == DATA_LAST);
  end

  sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sram (
    .clk_i   (SCK),
    .we_i    (mem_we),
    .waddr_i (addr_q),
    .wdata_i (rx_d),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // Frame FSM, bit counting, shift registers and registered pin outputs.
  always_ff @(negedge SCK) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      addr_sh_q   <= '0;
      addr_q      <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      is_read_q   <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      word_cnt_q  <= '0;
    end else if (bus.cs_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cmd_q     <= cmd_d;
          bit_cnt_q <= BIT_ONE;
          busy_q    <= 1'b1;
          state_q   <= ST_CMD;
        end
        ST_CMD: begin
          cmd_q <= cmd_d;
          if (bit_cnt_q == CMD_LAST) begin
            bit_cnt_q <= '0;
            if (cmd_d == CMD_WRITE) begin
              is_read_q <= 1'b0;
              state_q   <= ST_ADDR;
            end else if (cmd_d == CMD_READ) begin
              is_read_q <= 1'b1;
              state_q   <= ST_ADDR;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_IGNORE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_ONE;
          end
        end
        ST_ADDR: begin
          addr_sh_q <= addr_sh_d;
          if (bit_cnt_q == ADDR_LAST) begin
            bit_cnt_q <= '0;
            addr_q    <= addr_base_d;
            if (is_read_q) begin
              miso_q    <= rd_data[0];
              tx_q      <= rd_data >> 1;
              miso_oe_q <= 1'b1;
              state_q   <= ST_RDATA;
            end else begin
              state_q <= ST_WDATA;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_ONE;
          end
        end
        ST_WDATA: begin
          rx_q <= rx_d;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_q  <= '0;
            addr_q     <= addr_inc_d;
            word_cnt_q <= word_cnt_d;
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_ONE;
          end
        end
        ST_RDATA: begin
          // bit_cnt_q tracks which bit of the current word is on miso.
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_q  <= '0;
            addr_q     <= addr_inc_d;
            miso_q     <= rd_data[0];
            tx_q       <= rd_data >> 1;
            word_cnt_q <= word_cnt_d;
          end else begin
            miso_q    <= tx_q[0];
            tx_q      <= tx_q >> 1;
            bit_cnt_q <= bit_cnt_q + BIT_ONE;
          end
        end
        ST_IGNORE: begin
          bit_cnt_q <= '0;
        end
        default: begin
          state_q    <= ST_IDLE;
          bit_cnt_q  <= '0;
          miso_q     <= 1'b0;
          miso_oe_q  <= 1'b0;
          busy_q     <= 1'b0;
          word_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.miso      = miso_q;
  assign bus.miso_oe   = miso_oe_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_spi_sram_burst_slave.sv
// Bench for spi_sram_burst_slave: an 8/8/256 instance and a 16/4/12 instance checked
// bit-by-bit against a word-array memory model.
module tb_spi_sram_burst_slave;

  logic SCK = 1'b0;
  logic rst;

  spi_sram_burst_slave_if bus0 ();
  spi_sram_burst_slave_if bus1 ();

  spi_sram_burst_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) dut0 (
    .SCK (SCK), .rst (rst), .bus (bus0)
  );

  spi_sram_burst_slave #(.DATA_W(16), .ADDR_W(4), .DEPTH(12)) dut1 (
    .SCK (SCK), .rst (rst), .bus (bus1)
  );

  always #5 SCK = ~SCK;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref0 [256];
  logic [15:0] ref1 [12];
  logic [15:0] wq [$];

  function automatic int dw(input int sel);
    return (sel == 0) ? 8 : 16;
  endfunction

  function automatic int aw(input int sel);
    return (sel == 0) ? 8 : 4;
  endfunction

  function automatic int depth(input int sel);
    return (sel == 0) ? 256 : 12;
  endfunction

  function automatic logic model_bit(input int sel, input int idx, input int b);
    logic [15:0] w;
    w = (sel == 0) ? {8'h00, ref0[idx]} : ref1[idx];
    return w[b];
  endfunction

  function automatic logic [31:0] get_out(input int sel, input int which);
    logic [31:0] v;
    case (which)
      0:       v = (sel == 0) ? 32'(bus0.miso)      : 32'(bus1.miso);
      1:       v = (sel == 0) ? 32'(bus0.miso_oe)   : 32'(bus1.miso_oe);
      2:       v = (sel == 0) ? 32'(bus0.busy)      : 32'(bus1.busy);
      3:       v = (sel == 0) ? 32'(bus0.frame_err) : 32'(bus1.frame_err);
      default: v = (sel == 0) ? 32'(bus0.word_cnt)  : 32'(bus1.word_cnt);
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic clk_bit(input int sel, input logic cs, input logic d);
    @(posedge SCK);
    #1;
    if (sel == 0) begin
      bus0.cs_n = cs;
      bus0.mosi = d;
    end else begin
      bus1.cs_n = cs;
      bus1.mosi = d;
    end
    @(negedge SCK);
    #1;
  endtask

  task automatic send(input int sel, input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      clk_bit(sel, 1'b0, v[i]);
    end
  endtask

  task automatic chk_quiet(input int sel, input string tag);
    chk({tag, "_miso"}, get_out(sel, 0), 32'd0);
    chk({tag, "_oe"},   get_out(sel, 1), 32'd0);
    chk({tag, "_busy"}, get_out(sel, 2), 32'd0);
    chk({tag, "_ferr"}, get_out(sel, 3), 32'd0);
    chk({tag, "_wcnt"}, get_out(sel, 4), 32'd0);
  endtask

  task automatic end_frame(input int sel);
    clk_bit(sel, 1'b1, 1'b0);
    chk_quiet(sel, "end");
  endtask

  task automatic write_burst(input int sel, input int addr);
    int a;
    send(sel, 32'h02, 8);
    chk("wr_busy", get_out(sel, 2), 32'd1);
    send(sel, 32'(addr), aw(sel));
    a = addr % depth(sel);
    for (int i = 0; i < wq.size(); i++) begin
      send(sel, {16'h0000, wq[i]}, dw(sel));
      if (sel == 0) ref0[(a + i) % 256] = wq[i][7:0];
      else          ref1[(a + i) % 12]  = wq[i];
      chk("wr_wcnt", get_out(sel, 4), 32'(i + 1));
      chk("wr_oe", get_out(sel, 1), 32'd0);
    end
    end_frame(sel);
  endtask

  task automatic fill_random(input int n, input int sel);
    wq.delete();
    for (int i = 0; i < n; i++) begin
      wq.push_back((sel == 0) ? {8'h00, 8'($urandom)} : 16'($urandom));
    end
  endtask

  // Bit k after the address edge is bit k%DW of word (start + k/DW) mod DEPTH.
  task automatic read_burst(input int sel, input int addr, input int nwords);
    int a;
    int w;
    send(sel, 32'h03, 8);
    send(sel, 32'(addr), aw(sel));
    a = addr % depth(sel);
    w = dw(sel);
    for (int k = 0; k <= nwords * w; k++) begin
      if (k > 0) clk_bit(sel, 1'b0, 1'($urandom));
      chk("rd_miso", get_out(sel, 0), 32'(model_bit(sel, (a + k / w) % depth(sel), k % w)));
      chk("rd_oe",   get_out(sel, 1), 32'd1);
      chk("rd_wcnt", get_out(sel, 4), 32'(k / w));
    end
    end_frame(sel);
  endtask

  initial begin
    bus0.cs_n = 1'b1;
    bus0.mosi = 1'b0;
    bus1.cs_n = 1'b1;
    bus1.mosi = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge SCK);
    #1;
    chk_quiet(0, "reset0");
    chk_quiet(1, "reset1");
    @(posedge SCK);
    #1;
    rst = 1'b0;
    @(negedge SCK);
    #1;

    // Give every word a known value; the long burst also crosses the wrap point.
    fill_random(256, 0);
    write_burst(0, 0);
    fill_random(12, 1);
    write_burst(1, 5);

    // Single-word write then read at 0x10.
    wq.delete();
    wq.push_back(16'h00A5);
    write_burst(0, 8'h10);
    chk("t1_model", 32'(ref0[8'h10]), 32'hA5);
    read_burst(0, 8'h10, 1);

    // Burst across the top of the address space.
    wq.delete();
    wq.push_back(16'h0011);
    wq.push_back(16'h0022);
    wq.push_back(16'h0033);
    write_burst(0, 8'hFE);
    read_burst(0, 8'hFE, 3);

    // Unknown command: one-edge error pulse, pad never enabled.
    send(0, 32'h5A, 7);
    chk("ferr_pre", get_out(0, 3), 32'd0);
    send(0, 32'h00, 1);
    chk("ferr_hit", get_out(0, 3), 32'd1);
    chk("ferr_oe", get_out(0, 1), 32'd0);
    send(0, 32'h0302, 16);
    chk("ferr_clr", get_out(0, 3), 32'd0);
    chk("ferr_busy", get_out(0, 2), 32'd1);
    chk("ferr_oe2", get_out(0, 1), 32'd0);
    end_frame(0);

    // Aborted write after five data bits leaves memory untouched.
    send(0, 32'h02, 8);
    send(0, 32'h20, 8);
    send(0, 32'h1F, 5);
    chk("abort_wcnt", get_out(0, 4), 32'd0);
    end_frame(0);
    read_burst(0, 8'h20, 1);

    // Reset in the middle of a read burst, with cs_n still low.
    send(0, 32'h03, 8);
    send(0, 32'hFE, 8);
    send(0, 32'h0, 12);
    chk("pre_rst_oe", get_out(0, 1), 32'd1);
    @(posedge SCK);
    #1;
    rst = 1'b1;
    bus0.cs_n = 1'b0;
    @(negedge SCK);
    #1;
    chk_quiet(0, "midrst");
    @(posedge SCK);
    #1;
    rst = 1'b0;
    bus0.cs_n = 1'b1;
    @(negedge SCK);
    #1;
    read_burst(0, 8'hFE, 3);

    // Small non-power-of-two memory: wrap at 11 and out-of-range address.
    wq.delete();
    wq.push_back(16'hBEEF);
    wq.push_back(16'h1234);
    write_burst(1, 11);
    chk("t6_wrap", 32'(ref1[0]), 32'h1234);
    read_burst(1, 11, 2);
    wq.delete();
    wq.push_back(16'hC3A5);
    write_burst(1, 13);
    read_burst(1, 1, 1);
    read_burst(1, 14, 3);

    // Randomised bursts on both instances.
    for (int it = 0; it < 10; it++) begin
      int sel;
      int addr;
      int n;
      sel  = int'($urandom_range(1, 0));
      addr = int'($urandom_range((1 << aw(sel)) - 1, 0));
      n    = int'($urandom_range(5, 1));
      fill_random(n, sel);
      write_burst(sel, addr);
      read_burst(sel, addr, n);
      read_burst(sel, int'($urandom_range((1 << aw(sel)) - 1, 0)), int'($urandom_range(3, 1)));
    end

    // Whole-memory readback catches any stray writes.
    read_burst(0, 0, 256);
    read_burst(1, 7, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
